// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bundle for the fetch controller.
// master = fetch side (drives request), slave = memory side (drives ready/response).
interface fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req_valid;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_req_ready;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: one outstanding imem request, single-entry instruction buffer.
// Ports: clk/rst, i_pc/i_taken/i_stall in, o_pc_en + o_if_* out, imem bundle (master).
module fetch_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_taken,
  input  logic                  i_stall,
  output logic                  o_pc_en,
  fetch_ctrl_if.master          imem,
  output logic                  o_if_valid,
  output logic [DATA_WIDTH-1:0] o_if_inst,
  output logic [ADDR_WIDTH-1:0] o_if_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_kill;
  logic                  w_kill_nxt;
  logic [ADDR_WIDTH-1:0] r_req_pc;
  logic                  r_if_valid;
  logic [DATA_WIDTH-1:0] r_if_inst;
  logic [ADDR_WIDTH-1:0] r_if_pc;

  logic w_accept;
  logic w_rsp;
  logic w_rsp_keep;

  assign w_accept = (r_state == S_REQ) & imem.imem_req_ready;
  assign w_rsp    = (r_state == S_WAIT) & imem.imem_rsp_valid;
  // A response is kept only if neither an earlier nor a same-cycle
  // redirect has made it stale.
  assign w_rsp_keep = w_rsp & ~r_kill & ~i_taken;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: w_next = S_REQ;
      S_REQ: begin
        if (imem.imem_req_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rsp_valid) begin
          w_next = w_rsp_keep ? S_HOLD : S_REQ;
        end
      end
      S_HOLD: begin
        if (i_taken | ~i_stall) w_next = S_REQ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic; reset masks everything, including a redirect.
  always_comb begin
    o_pc_en             = 1'b0;
    imem.imem_req_valid = 1'b0;
    imem.imem_req_addr  = i_pc;
    if (!rst) begin
      o_pc_en = i_taken | ((r_state == S_HOLD) & ~i_stall);
      imem.imem_req_valid = (r_state == S_REQ);
    end
  end

  // Kill marks the single in-flight request as stale after a redirect.
  always_comb begin
    w_kill_nxt = 1'b0;
    unique case (r_state)
      S_REQ:  w_kill_nxt = w_accept & i_taken;
      S_WAIT: w_kill_nxt = ~imem.imem_rsp_valid & (r_kill | i_taken);
      default: w_kill_nxt = 1'b0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kill     <= 1'b0;
      r_req_pc   <= '0;
      r_if_valid <= 1'b0;
      r_if_inst  <= '0;
      r_if_pc    <= '0;
    end else begin
      r_kill     <= w_kill_nxt;
      r_if_valid <= (w_next == S_HOLD);
      if (w_accept) begin
        r_req_pc <= i_pc;
      end
      if (w_rsp_keep) begin
        r_if_inst <= imem.imem_rsp_data;
        r_if_pc   <= r_req_pc;
      end
    end
  end

  assign o_if_valid = r_if_valid;
  assign o_if_inst  = r_if_inst;
  assign o_if_pc    = r_if_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small PC-register model.
// Inputs change on negedge, outputs are sampled 1ns later.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        taken;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] tgt;
  logic        pc_en;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) imem ();

  fetch_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_pc       (pc),
    .i_taken    (taken),
    .i_stall    (stall),
    .o_pc_en    (pc_en),
    .imem       (imem.master),
    .o_if_valid (if_valid),
    .o_if_inst  (if_inst),
    .o_if_pc    (if_pc)
  );

  always #5 clk = ~clk;

  // PC register: redirect target on taken, else sequential.
  always @(posedge clk) begin
    if (rst) pc <= '0;
    else if (pc_en) pc <= taken ? tgt : pc + 32'd4;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input logic r, input logic t, input logic s,
                       input logic rdy, input logic rv,
                       input logic [31:0] d, input logic [31:0] tg);
    @(negedge clk);
    rst = r;
    taken = t;
    stall = s;
    imem.imem_req_ready = rdy;
    imem.imem_rsp_valid = rv;
    imem.imem_rsp_data = d;
    tgt = tg;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    taken = 1'b0;
    stall = 1'b0;
    tgt = '0;
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data = '0;

    // reset, taken masked
    drive(1, 1, 0, 1, 1, 32'hdead, 32'h40);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_req_v", imem.imem_req_valid, 0);
    drive(1, 0, 0, 1, 1, 32'hdead, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_if_pc", if_pc, 0);

    // basic fetch: IDLE, REQ, WAIT, HOLD
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("c0_idle_req_v", imem.imem_req_valid, 0);
    chk("c0_pc_en", pc_en, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("c1_req_v", imem.imem_req_valid, 1);
    chk("c1_addr", imem.imem_req_addr, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h13, 0);
    chk("c2_req_v", imem.imem_req_valid, 0);
    chk("c2_if_valid", if_valid, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("c3_if_valid", if_valid, 1);
    chk("c3_if_inst", if_inst, 32'h13);
    chk("c3_if_pc", if_pc, 0);
    chk("c3_pc_en", pc_en, 1);

    // stall in HOLD for 3 cycles
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("c4_addr", imem.imem_req_addr, 32'h4);
    drive(0, 0, 0, 0, 1, 32'haaaa0001, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0, 0, 0);
      chk("stall_if_valid", if_valid, 1);
      chk("stall_if_inst", if_inst, 32'haaaa0001);
      chk("stall_if_pc", if_pc, 32'h4);
      chk("stall_pc_en", pc_en, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("unstall_pc_en", pc_en, 1);
    chk("unstall_if_valid", if_valid, 1);

    // taken in WAIT, response two cycles later is dropped
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("c10_addr", imem.imem_req_addr, 32'h8);
    drive(0, 1, 0, 0, 0, 0, 32'h100);
    chk("wait_tk_pc_en", pc_en, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("wait_pc_en0", pc_en, 0);
    chk("wait_req_v0", imem.imem_req_valid, 0);
    drive(0, 0, 0, 0, 1, 32'hbad0, 0);
    chk("kill_if_valid", if_valid, 0);

    // ready low for 4 cycles in REQ
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("nrdy_req_v", imem.imem_req_valid, 1);
      chk("nrdy_addr", imem.imem_req_addr, 32'h100);
      chk("nrdy_pc_en", pc_en, 0);
      chk("nrdy_if_valid", if_valid, 0);
    end
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("acc_req_v", imem.imem_req_valid, 1);

    // taken and response in the same WAIT cycle
    drive(0, 1, 0, 0, 1, 32'hbad1, 32'h200);
    chk("same_pc_en", pc_en, 1);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("same_if_valid", if_valid, 0);
    chk("same_req_v", imem.imem_req_valid, 1);
    chk("same_addr", imem.imem_req_addr, 32'h200);
    drive(0, 0, 0, 0, 1, 32'h55, 0);

    // taken in HOLD while stalled
    drive(0, 1, 1, 0, 0, 0, 32'h300);
    chk("hold_tk_if_valid", if_valid, 1);
    chk("hold_tk_inst", if_inst, 32'h55);
    chk("hold_tk_if_pc", if_pc, 32'h200);
    chk("hold_tk_pc_en", pc_en, 1);

    // taken in REQ with ready low
    drive(0, 1, 0, 0, 0, 0, 32'h400);
    chk("htk_if_valid", if_valid, 0);
    chk("htk_req_v", imem.imem_req_valid, 1);
    chk("htk_addr", imem.imem_req_addr, 32'h300);
    chk("req_tk_pc_en", pc_en, 1);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("req_tk_addr", imem.imem_req_addr, 32'h400);

    // reset in WAIT, response right after reset is ignored
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'hbad2, 0);
    chk("post_rst_req_v", imem.imem_req_valid, 0);
    chk("post_rst_pc_en", pc_en, 0);
    drive(0, 1, 0, 1, 0, 0, 32'h500);
    chk("post_rst_if_valid", if_valid, 0);
    chk("post_rst_addr", imem.imem_req_addr, 32'h0);
    chk("reqacc_tk_pc_en", pc_en, 1);

    // taken with accept: old response must be discarded
    drive(0, 0, 0, 0, 1, 32'hbad3, 0);
    chk("acc_kill_if_valid", if_valid, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("acc_kill_if_valid2", if_valid, 0);
    chk("acc_kill_req_v", imem.imem_req_valid, 1);
    chk("acc_kill_addr", imem.imem_req_addr, 32'h500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, PC and instruction-memory address width.
REQ-002 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pc  input  ADDR_WIDTH  current PC from PC register.
REQ-006 taken  input  1  redirect from EX; PC loads branch target when pc_en=1.
REQ-007 stall  input  1  decode cannot accept an instruction this cycle.
REQ-008 pc_en  output  1  load enable to PC register.
REQ-009 imem_req_valid  output  1  fetch request to instruction memory.
REQ-010 imem_req_addr  output  ADDR_WIDTH  fetch address; equals pc.
REQ-011 imem_req_ready  input  1  memory accepts request; transfer on valid&ready.
REQ-012 imem_rsp_valid  input  1  response word valid, one cycle per accepted request, in order.
REQ-013 imem_rsp_data  input  DATA_WIDTH  response instruction word.
REQ-014 if_valid  output  1  instruction available to decode.
REQ-015 if_inst  output  DATA_WIDTH  buffered instruction.
REQ-016 if_pc  output  ADDR_WIDTH  address of if_inst.

Function
REQ-017 FSM states IDLE, REQ, WAIT, HOLD; one request outstanding at most.
REQ-018 IDLE: no request; next state REQ unconditionally.
REQ-019 REQ: imem_req_valid=1, imem_req_addr=pc; on ready, capture pc into req_pc, go WAIT; else stay REQ; address may change while not accepted (no stability rule).
REQ-020 WAIT: imem_req_valid=0; on imem_rsp_valid with kill=0, register data into if_inst, req_pc into if_pc, go HOLD.
REQ-021 HOLD: if_valid=1 (registered, only in HOLD); if stall=0 and taken=0, go REQ.
REQ-022 pc_en = taken | (HOLD & ~stall), combinational; 0 in all other cases.
REQ-023 Fetch latency: accepted request at cycle T, response at T+k, if_valid at T+k+1; PC advances on the edge leaving HOLD, so REQ sees the new pc.
REQ-024 taken in IDLE: pc_en=1; state goes REQ.
REQ-025 taken in REQ, ready=0: pc_en=1; stay REQ, next request uses redirected pc.
REQ-026 taken in REQ, ready=1: pc_en=1; old request accepted, go WAIT with kill=1.
REQ-027 taken in WAIT, no response: pc_en=1; set kill=1 (remains 1 if already set), stay WAIT.
REQ-028 taken in WAIT with response same cycle: response discarded, kill=0, go REQ.
REQ-029 Response in WAIT with kill=1: discarded, kill cleared, go REQ; if_valid stays 0.
REQ-030 taken in HOLD (any stall): buffer dropped, if_valid=0 next cycle, pc_en=1, go REQ.
REQ-031 imem_rsp_valid outside WAIT is ignored.

Reset
REQ-032 rst=1: state IDLE, kill=0, if_valid=0, if_inst=0, if_pc=0, req_pc=0, imem_req_valid=0, pc_en=0 (rst overrides taken).
REQ-033 rst mid-request/response: outstanding request abandoned; responses in the cycle after rst deasserts are ignored (state IDLE, not WAIT).

Verification
REQ-034 Reset, pc=0, ready=1, response 1 cycle after accept with 0x00000013, stall=0 -> req at cycle 1 addr 0, if_valid cycle 3 with if_inst=0x13 if_pc=0, pc_en pulse cycle 3.
REQ-035 HOLD with stall=1 for 3 cycles -> if_valid/if_inst/if_pc held, pc_en=0 throughout, pc_en=1 on first stall=0 cycle.
REQ-036 taken in WAIT, response 2 cycles later -> pc_en=1 once, response dropped, if_valid never asserted, next request addr = new pc.
REQ-037 taken and imem_rsp_valid same cycle in WAIT -> no if_valid, state REQ next cycle.
REQ-038 taken in HOLD with stall=1 -> pc_en=1, if_valid=0 next cycle, request on redirected pc.
REQ-039 ready held 0 for 4 cycles in REQ -> imem_req_valid stays 1, pc_en=0, no state change.
